// File: rtl/hc4_uart_tx_port_pkg.sv
// Shared definitions for the HC4 nibble-bus UART transmitter: register offsets,
// status bit positions, shifter state encoding and the status nibble packer.
// Latency: n/a (definitions only). Backpressure: n/a.
package hc4_uart_tx_port_pkg;

    // Register offsets inside the 3-nibble window, relative to BASE_ADDR
    localparam logic [1:0] REG_LO   = 2'd0;
    localparam logic [1:0] REG_HI   = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;

    // Bit positions inside the status nibble
    localparam int ST_OVF   = 3;
    localparam int ST_ACT   = 2;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 0;

    // Serial shifter states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Assemble the status nibble from its individual flags
    function automatic logic [3:0] status_nibble(
        input logic ovf,
        input logic act,
        input logic full,
        input logic empty
    );
        logic [3:0] v;
        v           = 4'b0000;
        v[ST_OVF]   = ovf;
        v[ST_ACT]   = act;
        v[ST_FULL]  = full;
        v[ST_EMPTY] = empty;
        return v;
    endfunction

endpackage

// File: rtl/hc4_uart_tx_port_fifo.sv
// Small byte FIFO between the nibble-bus write side and the serial shifter.
// Latency: a push is visible on dout/empty one clk later (registered write, show-ahead read).
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module hc4_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra pointer bit distinguishes full from empty when the indices match
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [7:0]    r_mem [DEPTH];

    logic          w_do_wr;
    logic          w_do_rd;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees the slot in the same cycle, so a push at full still lands
    assign w_do_wr = push && (!full || pop);
    assign w_do_rd = pop && !empty;

    // Head entry is always presented so the reader can take it on the pop edge
    assign dout    = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array: written on accepted pushes only, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read and write pointers, wrapping modulo 2*DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/hc4_uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter on the HC4 nibble bus: lo/hi nibble writes push a byte, status nibble readable.
// Latency: byte push to first start-bit cycle on txd is 2 clk when idle; each frame is 10*CLKS_PER_BIT clk.
// Backpressure: none on the bus; a push into a full FIFO with no simultaneous pop is dropped and sets sticky overflow.
module hc4_uart_tx_port
    import hc4_uart_tx_port_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR    = 8'hF2,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [7:0] address_bus,
    inout  wire  [3:0] data_bus,
    input  logic       nRAM_WR,
    input  logic       nRAM_RD,
    output logic       sel_out,
    output logic       txd,
    output logic       tx_busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    logic [7:0] w_off;
    logic       w_in_win;
    logic [1:0] w_reg;
    logic [3:0] w_wdat;

    assign w_off    = address_bus - BASE_ADDR;
    assign w_in_win = (w_off < 8'd3);
    assign w_reg    = w_off[1:0];
    assign w_wdat   = data_bus;
    assign sel_out  = w_in_win;

    // ---------------------------------------------------------------
    // Write strobe edge detect: one write per falling edge of nRAM_WR
    // ---------------------------------------------------------------
    logic r_wr_q;
    logic w_wr_stb;
    logic w_lo_wr;
    logic w_push;
    logic w_stat_wr;

    // Delayed copy of the write strobe; idles high so reset never fakes an edge
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_wr_q <= 1'b1;
        end else begin
            r_wr_q <= nRAM_WR;
        end
    end

    assign w_wr_stb  = r_wr_q && !nRAM_WR;
    assign w_lo_wr   = w_wr_stb && w_in_win && (w_reg == REG_LO);
    assign w_push    = w_wr_stb && w_in_win && (w_reg == REG_HI);
    assign w_stat_wr = w_wr_stb && w_in_win && (w_reg == REG_STAT);

    // ---------------------------------------------------------------
    // Low nibble latch and overflow flag
    // ---------------------------------------------------------------
    logic [3:0] r_lo;
    logic       r_ovf;

    // Low nibble holds across pushes so repeated hi writes reuse it
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_lo <= 4'd0;
        end else if (w_lo_wr) begin
            r_lo <= w_wdat;
        end
    end

    // ---------------------------------------------------------------
    // Byte FIFO
    // ---------------------------------------------------------------
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;

    hc4_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (Reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({w_wdat, r_lo}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Overflow is sticky until software writes the status register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_stat_wr) begin
            r_ovf <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Serial shifter
    // ---------------------------------------------------------------
    tx_state_t         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_txd;
    logic              r_busy;
    logic              w_baud_last;

    assign w_baud_last = (r_baud == BAUD_LAST);

    // The shifter takes the head byte only from IDLE; a byte pushed this
    // cycle is not yet visible, so it waits in the FIFO until next cycle
    assign w_pop = (r_state == TX_IDLE) && !w_empty;

    // Frame sequencer; txd is registered from the current state so the line
    // trails the state by one clk and never glitches
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                TX_START: r_txd <= 1'b0;
                TX_DATA:  r_txd <= r_shift[0];
                default:  r_txd <= 1'b1;
            endcase

            case (r_state)
                TX_IDLE: begin
                    r_baud <= '0;
                    r_bit  <= 3'd0;
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_state <= TX_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                TX_DATA: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= TX_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                TX_STOP: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= TX_IDLE;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Busy covers both queued bytes and a frame in flight
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= !w_empty || (r_state != TX_IDLE);
        end
    end

    assign txd     = r_txd;
    assign tx_busy = r_busy;

    // ---------------------------------------------------------------
    // Status read: only the status register drives the bus
    // ---------------------------------------------------------------
    logic [3:0] w_status;
    logic       w_stat_rd;

    assign w_status  = status_nibble(r_ovf, (r_state != TX_IDLE), w_full, w_empty);
    assign w_stat_rd = !Reset && !nRAM_RD && w_in_win && (w_reg == REG_STAT);
    assign data_bus  = w_stat_rd ? w_status : 4'bzzzz;

endmodule
